// File: rtl/jesd_rx_pkg.sv
// Shared JESD204B receive-side definitions: link states, control characters,
// link multiplexer encodings and the error-report sub-FSM states.
package jesd_rx_pkg;

  typedef enum logic [2:0] {
    ST_CS_INIT    = 3'd0,
    ST_CS_CHECK   = 3'd1,
    ST_ILA_WAIT_R = 3'd2,
    ST_ILA_RECV   = 3'd3,
    ST_DATA       = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_ARMED = 2'd1,
    RPT_LOW   = 2'd2
  } rpt_state_e;

  typedef enum logic [1:0] {
    LINK_MUX_DATA = 2'd0,
    LINK_MUX_CGS  = 2'd1,
    LINK_MUX_ILA  = 2'd2
  } link_mux_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;

  function automatic logic is_ctrl(input logic ok, input logic k,
                                   input logic [7:0] ch, input logic [7:0] code);
    return ok & k & (ch == code);
  endfunction

endpackage

// File: rtl/jesd_rx_err_report.sv
// SYNC~ error-report timer: once armed, pulls SYNC~ low from the next frame
// boundary for ERR_REPORT_FRAMES frame periods. New arms are ignored while busy.
module jesd_rx_err_report
  import jesd_rx_pkg::*;
#(
  parameter int unsigned ERR_REPORT_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_arm,
  input  logic i_frame_clk,
  output logic o_sync_low
);

  localparam int unsigned FW = $clog2(ERR_REPORT_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(ERR_REPORT_FRAMES - 1);

  rpt_state_e    state_q, state_d;
  logic [FW-1:0] frames_q, frames_d;

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    if (i_clr) begin
      state_d  = RPT_IDLE;
      frames_d = '0;
    end else begin
      case (state_q)
        RPT_IDLE:  if (i_arm) state_d = RPT_ARMED;
        RPT_ARMED: begin
          if (i_frame_clk) begin
            state_d  = RPT_LOW;
            frames_d = '0;
          end
        end
        RPT_LOW: begin
          // The strobe that started the report is not counted; the report
          // ends on the ERR_REPORT_FRAMES-th strobe after it.
          if (i_frame_clk) begin
            if (frames_q == F_LAST) begin
              state_d  = RPT_IDLE;
              frames_d = '0;
            end else begin
              frames_d = frames_q + FW'(1);
            end
          end
        end
        default: begin
          state_d  = RPT_IDLE;
          frames_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RPT_IDLE;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
    end
  end

  assign o_sync_low = (state_q == RPT_LOW);

endmodule

// File: rtl/cgs_ila_rx_fsm.sv
// JESD204B receive lane link controller: CGS, ILA checking, DATA gating and
// SYNC~ error reporting. All outputs are registered one cycle after the input.
module cgs_ila_rx_fsm
  import jesd_rx_pkg::*;
#(
  parameter int unsigned K_CNT_THRESH      = 4,
  parameter int unsigned BAD_CNT_THRESH    = 4,
  parameter int unsigned ERR_REPORT_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_clk,
  input  logic       lmfc_clk,
  input  logic       i_char_valid,
  input  logic [7:0] i_char,
  input  logic       i_is_k,
  input  logic       i_disp_err,
  input  logic       i_nit_err,
  input  logic       i_link_reinit,
  input  logic [7:0] i_ila_multiframe_length,
  output logic       o_sync_n,
  output logic [2:0] o_state,
  output logic       o_data_valid,
  output logic       o_ila_done,
  output logic       o_ila_err,
  output logic [7:0] o_err_cnt
);

  localparam int unsigned KW = $clog2(K_CNT_THRESH + 1);
  localparam int unsigned BW = $clog2(BAD_CNT_THRESH + 1);
  localparam logic [KW-1:0] K_LAST = KW'(K_CNT_THRESH - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAD_CNT_THRESH - 1);

  rx_state_e     state_q, state_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d, bad_next;
  logic [8:0]    mf_cnt_q, mf_cnt_d;
  logic [8:0]    lmfc_to_q, lmfc_to_d;
  logic          sync_q, sync_d;
  logic          data_valid_q, data_valid_d;
  logic          ila_done_q, ila_done_d;
  logic          ila_err_q, ila_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          go_init, rpt_arm, rpt_low;

  // Handshake: i_char_valid qualifies every char input for that cycle only;
  // o_data_valid qualifies the same octet one cycle later. No backpressure.
  logic char_bad, char_ok, is_k28_5, is_r, is_a, bad_hit, ila_complete;
  logic [8:0] ila_last, to_inc, to_lim;

  assign char_bad = i_char_valid & (i_disp_err | i_nit_err);
  assign char_ok  = i_char_valid & ~char_bad;
  assign is_k28_5 = is_ctrl(char_ok, i_is_k, i_char, K28_5);
  assign is_r     = is_ctrl(char_ok, i_is_k, i_char, K28_0);
  assign is_a     = is_ctrl(char_ok, i_is_k, i_char, K28_3);
  assign bad_next = char_bad ? (bad_cnt_q + BW'(1)) : (i_char_valid ? '0 : bad_cnt_q);
  assign bad_hit  = char_bad & (bad_cnt_q == B_LAST);

  assign ila_last     = {1'b0, i_ila_multiframe_length};
  assign to_inc       = lmfc_to_q + 9'd1;
  assign to_lim       = ila_last + 9'd2;
  assign ila_complete = is_a & (mf_cnt_q == ila_last);

  always_comb begin
    state_d      = state_q;
    k_cnt_d      = k_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    mf_cnt_d     = mf_cnt_q;
    lmfc_to_d    = lmfc_to_q;
    sync_d       = sync_q;
    data_valid_d = 1'b0;
    ila_done_d   = 1'b0;
    ila_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    go_init      = 1'b0;
    rpt_arm      = 1'b0;

    case (state_q)
      ST_CS_INIT: begin
        sync_d = 1'b0;
        if (is_k28_5) begin
          if (k_cnt_q == K_LAST) begin
            state_d = ST_CS_CHECK;
            k_cnt_d = '0;
          end else begin
            k_cnt_d = k_cnt_q + KW'(1);
          end
        end else if (i_char_valid) begin
          k_cnt_d = '0;
        end
      end
      ST_CS_CHECK: begin
        bad_cnt_d = bad_next;
        if (bad_hit) begin
          go_init = 1'b1;
        end else if (lmfc_clk) begin
          sync_d  = 1'b1;
          state_d = ST_ILA_WAIT_R;
        end
      end
      ST_ILA_WAIT_R: begin
        bad_cnt_d = bad_next;
        if (bad_hit) begin
          go_init = 1'b1;
        end else if (char_ok && !is_k28_5) begin
          if (is_r) begin
            state_d   = ST_ILA_RECV;
            mf_cnt_d  = '0;
            lmfc_to_d = '0;
          end else begin
            ila_err_d = 1'b1;
            go_init   = 1'b1;
          end
        end
      end
      ST_ILA_RECV: begin
        if (char_bad) begin
          ila_err_d = 1'b1;
          go_init   = 1'b1;
        end else begin
          if (is_a) mf_cnt_d = mf_cnt_q + 9'd1;
          if (lmfc_clk) lmfc_to_d = to_inc;
          // A completing /A/ takes precedence over a timeout in the same cycle.
          if (ila_complete) begin
            ila_done_d = 1'b1;
            state_d    = ST_DATA;
          end else if (lmfc_clk && (to_inc > to_lim)) begin
            ila_err_d = 1'b1;
            go_init   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        data_valid_d = char_ok;
        if (char_bad) begin
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);
          rpt_arm   = 1'b1;
        end
      end
      default: go_init = 1'b1;
    endcase

    if (i_link_reinit) begin
      go_init      = 1'b1;
      data_valid_d = 1'b0;
      ila_done_d   = 1'b0;
      ila_err_d    = 1'b0;
      err_cnt_d    = err_cnt_q;
      rpt_arm      = 1'b0;
      k_cnt_d      = '0;
    end

    if (go_init) begin
      state_d   = ST_CS_INIT;
      sync_d    = 1'b0;
      k_cnt_d   = '0;
      bad_cnt_d = '0;
      mf_cnt_d  = '0;
      lmfc_to_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CS_INIT;
      k_cnt_q      <= '0;
      bad_cnt_q    <= '0;
      mf_cnt_q     <= '0;
      lmfc_to_q    <= '0;
      sync_q       <= 1'b0;
      data_valid_q <= 1'b0;
      ila_done_q   <= 1'b0;
      ila_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      k_cnt_q      <= k_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      mf_cnt_q     <= mf_cnt_d;
      lmfc_to_q    <= lmfc_to_d;
      sync_q       <= sync_d;
      data_valid_q <= data_valid_d;
      ila_done_q   <= ila_done_d;
      ila_err_q    <= ila_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // The report timer only runs in DATA; leaving DATA discards any pending report.
  jesd_rx_err_report #(
    .ERR_REPORT_FRAMES(ERR_REPORT_FRAMES)
  ) u_err_report (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (state_q != ST_DATA),
    .i_arm      (rpt_arm),
    .i_frame_clk(frame_clk),
    .o_sync_low (rpt_low)
  );

  assign o_sync_n     = sync_q & ~rpt_low;
  assign o_state      = state_q;
  assign o_data_valid = data_valid_q;
  assign o_ila_done   = ila_done_q;
  assign o_ila_err    = ila_err_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cgs_ila_rx_fsm.sv
// Self-checking bench for cgs_ila_rx_fsm: each driven cycle queues the expected
// registered outputs, which are compared one clock later.
module tb_cgs_ila_rx_fsm;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WAITR = 3'd2;
  localparam logic [2:0] S_RECV  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic       sn;
    logic       dv;
    logic       dn;
    logic       er;
    logic [7:0] ec;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic       clk, rst_n;
  logic       frame_clk, lmfc_clk;
  logic       i_char_valid, i_is_k, i_disp_err, i_nit_err, i_link_reinit;
  logic [7:0] i_char, i_ila_multiframe_length;
  logic       o_sync_n, o_data_valid, o_ila_done, o_ila_err;
  logic [2:0] o_state;
  logic [7:0] o_err_cnt;

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       exp_ec;
  logic             nit_nx, reinit_nx;
  int               n_checks, n_pass;
  exp_t             mon_e;

  cgs_ila_rx_fsm dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .frame_clk              (frame_clk),
    .lmfc_clk               (lmfc_clk),
    .i_char_valid           (i_char_valid),
    .i_char                 (i_char),
    .i_is_k                 (i_is_k),
    .i_disp_err             (i_disp_err),
    .i_nit_err              (i_nit_err),
    .i_link_reinit          (i_link_reinit),
    .i_ila_multiframe_length(i_ila_multiframe_length),
    .o_sync_n               (o_sync_n),
    .o_state                (o_state),
    .o_data_valid           (o_data_valid),
    .o_ila_done             (o_ila_done),
    .o_ila_err              (o_ila_err),
    .o_err_cnt              (o_err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // scoreboard: outputs seen after each active edge against the queued entry
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("state",      32'(o_state),      32'(mon_e.st));
      check_eq("sync_n",     32'(o_sync_n),     32'(mon_e.sn));
      check_eq("data_valid", 32'(o_data_valid), 32'(mon_e.dv));
      check_eq("ila_done",   32'(o_ila_done),   32'(mon_e.dn));
      check_eq("ila_err",    32'(o_ila_err),    32'(mon_e.er));
      check_eq("err_cnt",    32'(o_err_cnt),    32'(mon_e.ec));
    end
  end

  // driver tasks
  task automatic step(input logic cv, input logic [7:0] ch, input logic k, input logic de,
                      input logic lm, input logic fr, input logic [2:0] st, input logic sn,
                      input logic dv, input logic dn, input logic er);
    exp_t e;
    @(negedge clk);
    i_char_valid  = cv;
    i_char        = ch;
    i_is_k        = k;
    i_disp_err    = de;
    i_nit_err     = nit_nx;
    i_link_reinit = reinit_nx;
    lmfc_clk      = lm;
    frame_clk     = fr;
    e.st = st; e.sn = sn; e.dv = dv; e.dn = dn; e.er = er; e.ec = exp_ec;
    exp_q.push_back(e);
  endtask

  task automatic send_k(input logic [2:0] st, input logic sn);
    step(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, st, sn, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic [2:0] st, input logic sn);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, st, sn, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic link_up();
    repeat (3) send_k(S_INIT, 1'b0);
    send_k(S_CHECK, 1'b0);
    idle(S_CHECK, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_WAITR, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic cv, de, fr, sn, dv;
    n_checks = 0; n_pass = 0;
    exp_ec = 8'd0; nit_nx = 1'b0; reinit_nx = 1'b0;
    rst_n = 1'b0; frame_clk = 1'b0; lmfc_clk = 1'b0;
    i_char_valid = 1'b0; i_char = 8'h00; i_is_k = 1'b0;
    i_disp_err = 1'b0; i_nit_err = 1'b0; i_link_reinit = 1'b0;
    i_ila_multiframe_length = 8'd3;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state",  32'(o_state),      32'(S_INIT));
    check_eq("rst_sync_n", 32'(o_sync_n),     32'd0);
    check_eq("rst_dv",     32'(o_data_valid), 32'd0);
    check_eq("rst_done",   32'(o_ila_done),   32'd0);
    check_eq("rst_err",    32'(o_ila_err),    32'd0);
    check_eq("rst_errcnt", 32'(o_err_cnt),    32'd0);
    @(negedge clk) rst_n = 1'b1;

    // broken /K/ run restarts the count
    repeat (3) send_k(S_INIT, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) send_k(S_INIT, 1'b0);
    send_k(S_CHECK, 1'b0);

    // LMFC strobe 10 cycles later releases SYNC~
    repeat (9) idle(S_CHECK, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_WAITR, 1'b1, 1'b0, 1'b0, 1'b0);

    // ILA with length 3 (4 multiframes)
    repeat (2) send_k(S_WAITR, 1'b1);
    step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int mf = 0; mf < 4; mf++) begin
      step(1'b1, 8'($urandom_range(0, 123)), 1'b0, 1'b0, 1'b1, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
      if (mf == 1) step(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'($urandom_range(0, 123)), 1'b0, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
      if (mf == 3) step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, S_DATA, 1'b1, 1'b0, 1'b1, 1'b0);
      else         step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // DATA: o_data_valid follows i_char_valid
    for (int i = 0; i < 8; i++) begin
      cv = 1'($urandom_range(0, 1));
      step(cv, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0, S_DATA, 1'b1, cv, 1'b0, 1'b0);
    end

    // error reports: frame strobe every 4 cycles at n%4==3
    for (int n = 0; n < 24; n++) begin
      de     = (n == 0) || (n == 4);
      nit_nx = (n == 13);
      fr     = (n % 4 == 3);
      if (de || nit_nx) exp_ec = exp_ec + 8'd1;
      sn = !(((n >= 3) && (n <= 10)) || ((n >= 15) && (n <= 22)));
      dv = !(de || nit_nx);
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, de, 1'b0, fr, S_DATA, sn, dv, 1'b0, 1'b0);
    end
    nit_nx = 1'b0;

    // error counter saturation (no frame strobes, so SYNC~ stays high)
    for (int i = 0; i < 260; i++) begin
      if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
      step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, S_DATA, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // asynchronous reset while in DATA
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("arst_state",  32'(o_state),      32'(S_INIT));
    check_eq("arst_sync_n", 32'(o_sync_n),     32'd0);
    check_eq("arst_dv",     32'(o_data_valid), 32'd0);
    check_eq("arst_done",   32'(o_ila_done),   32'd0);
    check_eq("arst_err",    32'(o_ila_err),    32'd0);
    check_eq("arst_errcnt", 32'(o_err_cnt),    32'd0);
    exp_ec = 8'd0;
    @(negedge clk) rst_n = 1'b1;

    // non-/R/ in ILA_WAIT_R
    link_up();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(S_INIT, 1'b0);

    // link reinit mid ILA_RECV; /K/ must not count while it is held
    link_up();
    step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    reinit_nx = 1'b1;
    repeat (5) send_k(S_INIT, 1'b0);
    reinit_nx = 1'b0;
    repeat (3) send_k(S_INIT, 1'b0);
    send_k(S_CHECK, 1'b0);

    // ILA timeout: 6th LMFC strobe without completion exceeds length+2
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_WAITR, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_RECV, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, S_INIT, 1'b0, 1'b0, 1'b0, 1'b1);

    // bad-char threshold in CS_CHECK beats a simultaneous LMFC strobe
    repeat (3) send_k(S_INIT, 1'b0);
    send_k(S_CHECK, 1'b0);
    repeat (3) step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, S_CHECK, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, S_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(S_INIT, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check_eq("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
